// File: rtl/cactus_collision_detector.sv
// Scans four cactus slots against the dino hitbox once per position update,
// confirming collisions over consecutive scans and counting cactuses passed.
module cactus_collision_detector #(
  parameter int DINO_X      = 100,
  parameter int DINO_W      = 40,
  parameter int CACTUS_W    = 24,
  parameter int CACTUS_H    = 48,
  parameter int HIT_CONFIRM = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] cactus0,
  input  logic [11:0] cactus1,
  input  logic [11:0] cactus2,
  input  logic [11:0] cactus3,
  input  logic        cactus_sync,
  input  logic [9:0]  dino_alt,
  input  logic        restart,
  output logic        game_over,
  output logic [1:0]  hit_index,
  output logic [15:0] score,
  output logic        scan_done
);

  localparam logic [12:0] LEFT_EDGE  = 13'(DINO_X);
  localparam logic [12:0] RIGHT_EDGE = 13'(DINO_X + DINO_W - 1);
  localparam logic [12:0] CW_M1      = 13'(CACTUS_W - 1);
  localparam logic [9:0]  ALT_LIM    = 10'(CACTUS_H);
  localparam logic [2:0]  CONFIRM    = 3'(HIT_CONFIRM);

  typedef enum logic [1:0] {IDLE, SCAN, EVAL, OVER} state_t;

  state_t      state;
  logic [11:0] snap_p0 [4];
  logic [9:0]  alt_p0;
  logic [11:0] prev [4];
  logic [1:0]  slot;
  logic [3:0]  ovl_mask;
  logic [2:0]  pass_cnt;
  logic [2:0]  hit_cnt;
  logic        any_ovl;
  logic [2:0]  cnt_next;
  logic        confirm;
  logic [1:0]  first_idx;

  function automatic logic overlap_f(input logic [11:0] c, input logic [9:0] alt);
    logic [12:0] cz;
    cz = {1'b0, c};
    return !c[11] && (cz <= RIGHT_EDGE) && ((cz + CW_M1) >= LEFT_EDGE) && (alt < ALT_LIM);
  endfunction

  function automatic logic pass_f(input logic [11:0] p, input logic [11:0] c);
    return !p[11] && !c[11] && ({1'b0, p} <= RIGHT_EDGE) && ({1'b0, c} > RIGHT_EDGE);
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] s, input logic [2:0] n);
    logic [16:0] sum;
    sum = {1'b0, s} + {14'b0, n};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  always_comb begin
    any_ovl   = |ovl_mask;
    cnt_next  = any_ovl ? hit_cnt + 3'd1 : 3'd0;
    confirm   = any_ovl && (cnt_next >= CONFIRM);
    first_idx = 2'd0;
    if (ovl_mask[0])      first_idx = 2'd0;
    else if (ovl_mask[1]) first_idx = 2'd1;
    else if (ovl_mask[2]) first_idx = 2'd2;
    else if (ovl_mask[3]) first_idx = 2'd3;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      game_over <= 1'b0;
      score     <= 16'd0;
      hit_index <= 2'd0;
      scan_done <= 1'b0;
      hit_cnt   <= 3'd0;
      slot      <= 2'd0;
      ovl_mask  <= 4'd0;
      pass_cnt  <= 3'd0;
      alt_p0    <= 10'd0;
      for (int i = 0; i < 4; i++) begin
        snap_p0[i] <= 12'd0;
        prev[i]    <= 12'hFFF;
      end
    end else begin
      scan_done <= 1'b0;
      if (restart) begin
        state     <= IDLE;
        game_over <= 1'b0;
        score     <= 16'd0;
        hit_index <= 2'd0;
        hit_cnt   <= 3'd0;
        for (int i = 0; i < 4; i++) prev[i] <= 12'hFFF;
      end else begin
        case (state)
          // Stage p0: capture a consistent snapshot of all slots and the dino height
          IDLE: if (cactus_sync) begin
            snap_p0[0] <= cactus0;
            snap_p0[1] <= cactus1;
            snap_p0[2] <= cactus2;
            snap_p0[3] <= cactus3;
            alt_p0     <= dino_alt;
            slot       <= 2'd0;
            ovl_mask   <= 4'd0;
            pass_cnt   <= 3'd0;
            state      <= SCAN;
          end
          // One slot per cycle: accumulate overlap mask and pass count
          SCAN: begin
            ovl_mask[slot] <= overlap_f(snap_p0[slot], alt_p0);
            pass_cnt       <= pass_cnt + {2'b0, pass_f(prev[slot], snap_p0[slot])};
            slot           <= slot + 2'd1;
            if (slot == 2'd3) state <= EVAL;
          end
          // Register scan results; a confirming scan leaves score untouched
          EVAL: begin
            hit_cnt   <= cnt_next;
            scan_done <= 1'b1;
            for (int i = 0; i < 4; i++) prev[i] <= snap_p0[i];
            if (any_ovl) hit_index <= first_idx;
            if (confirm) begin
              game_over <= 1'b1;
              state     <= OVER;
            end else begin
              score <= sat_add(score, pass_cnt);
              state <= IDLE;
            end
          end
          OVER: state <= OVER;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cactus_collision_detector.sv
// Directed-vector bench: stimulus pushes expected scan results, a monitor
// pops and compares them whenever scan_done pulses.
module tb_cactus_collision_detector;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] cactus0, cactus1, cactus2, cactus3;
  logic        cactus_sync;
  logic [9:0]  dino_alt;
  logic        restart;
  logic        game_over;
  logic [1:0]  hit_index;
  logic [15:0] score;
  logic        scan_done;

  typedef struct {
    logic        go;
    logic [1:0]  hi;
    logic [15:0] sc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  cactus_collision_detector dut (
    .clk(clk), .rst(rst),
    .cactus0(cactus0), .cactus1(cactus1), .cactus2(cactus2), .cactus3(cactus3),
    .cactus_sync(cactus_sync), .dino_alt(dino_alt), .restart(restart),
    .game_over(game_over), .hit_index(hit_index), .score(score), .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every scan_done pulse must match the oldest pending expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (scan_done === 1'b1) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_scan_done: got 1 expected no pulse at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("game_over", 32'(game_over), 32'(e.go));
          chk("hit_index", 32'(hit_index), 32'(e.hi));
          chk("score", 32'(score), 32'(e.sc));
        end
      end
    end
  end

  task automatic set_pos(input logic [11:0] c0, c1, c2, c3, input logic [9:0] alt);
    cactus0 = c0; cactus1 = c1; cactus2 = c2; cactus3 = c3; dino_alt = alt;
  endtask

  task automatic do_scan(input logic [11:0] c0, c1, c2, c3, input logic [9:0] alt,
                         input logic go, input logic [1:0] hi, input logic [15:0] sc,
                         input bit sync_at_e2);
    exp_t e;
    @(negedge clk);
    set_pos(c0, c1, c2, c3, alt);
    cactus_sync = 1'b1;
    e.go = go; e.hi = hi; e.sc = sc;
    q.push_back(e);
    @(posedge clk); #1 cactus_sync = 1'b0;
    @(posedge clk); #1 if (sync_at_e2) cactus_sync = 1'b1;
    @(posedge clk); #1 cactus_sync = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 chk("scan_done_e4", 32'(scan_done), 32'd0);
    @(posedge clk); #1 chk("scan_done_e5", 32'(scan_done), 32'd1);
  endtask

  localparam logic [11:0] OFF = 12'hC00;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; restart = 1'b0; cactus_sync = 1'b0;
    set_pos(OFF, OFF, OFF, OFF, 10'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_game_over", 32'(game_over), 32'd0);
    chk("rst_hit_index", 32'(hit_index), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_scan_done", 32'(scan_done), 32'd0);
    @(negedge clk) rst = 1'b1;

    do_scan(OFF, OFF, OFF, OFF, 10'd0, 1'b0, 2'd0, 16'd0, 1'b0);

    // Two overlapping scans confirm the hit
    do_scan(12'd110, OFF, OFF, OFF, 10'd0, 1'b0, 2'd0, 16'd0, 1'b0);
    repeat (14) @(posedge clk);
    do_scan(12'd110, OFF, OFF, OFF, 10'd0, 1'b1, 2'd0, 16'd0, 1'b0);
    @(negedge clk) cactus_sync = 1'b1;
    @(negedge clk) cactus_sync = 1'b0;
    repeat (10) @(negedge clk);
    chk("over_hold_go", 32'(game_over), 32'd1);
    @(negedge clk) restart = 1'b1;
    @(posedge clk); #1 restart = 1'b0;
    chk("restart_go", 32'(game_over), 32'd0);
    chk("restart_score", 32'(score), 32'd0);
    chk("restart_hi", 32'(hit_index), 32'd0);

    // Jump clearance
    for (int i = 0; i < 5; i++)
      do_scan(12'd110, OFF, OFF, OFF, 10'd60, 1'b0, 2'd0, 16'd0, 1'b0);
    chk("jump_hit_cnt", 32'(dut.hit_cnt), 32'd0);

    // Scoring, wrap to off-screen, multi-slot passes
    do_scan(OFF, OFF, 12'd130, OFF, 10'd0, 1'b0, 2'd2, 16'd0, 1'b0);
    do_scan(OFF, OFF, 12'd145, OFF, 10'd0, 1'b0, 2'd2, 16'd1, 1'b0);
    do_scan(OFF, OFF, 12'hFCE, OFF, 10'd0, 1'b0, 2'd2, 16'd1, 1'b0);
    do_scan(12'd130, 12'd130, 12'd130, 12'd130, 10'd0, 1'b0, 2'd0, 16'd1, 1'b0);
    do_scan(12'd145, 12'd145, 12'd145, 12'd145, 10'd0, 1'b0, 2'd0, 16'd5, 1'b0);

    // Sync during a scan is dropped
    do_scan(OFF, OFF, OFF, OFF, 10'd0, 1'b0, 2'd0, 16'd5, 1'b1);
    repeat (10) @(negedge clk);

    // Restart discards an in-flight scan
    @(negedge clk);
    set_pos(12'd110, OFF, OFF, OFF, 10'd0);
    cactus_sync = 1'b1;
    @(posedge clk); #1 cactus_sync = 1'b0;
    @(posedge clk); #1 restart = 1'b1;
    @(posedge clk); #1 restart = 1'b0;
    chk("midscan_restart_score", 32'(score), 32'd0);
    chk("midscan_restart_sd", 32'(scan_done), 32'd0);
    repeat (8) @(negedge clk);
    do_scan(OFF, OFF, OFF, OFF, 10'd0, 1'b0, 2'd0, 16'd0, 1'b0);

    // Async reset at E3 of an overlapping scan
    @(negedge clk);
    set_pos(12'd110, OFF, OFF, OFF, 10'd0);
    cactus_sync = 1'b1;
    @(posedge clk); #1 cactus_sync = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("arst_score", 32'(score), 32'd0);
    chk("arst_go", 32'(game_over), 32'd0);
    chk("arst_sd", 32'(scan_done), 32'd0);
    chk("arst_hit_cnt", 32'(dut.hit_cnt), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    do_scan(12'd110, OFF, OFF, OFF, 10'd0, 1'b0, 2'd0, 16'd0, 1'b0);
    do_scan(12'd110, OFF, OFF, OFF, 10'd0, 1'b1, 2'd0, 16'd0, 1'b0);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cactus_collision_detector.md
CACTUS_COLLISION_DETECTOR -- requirements
Module: cactus_collision_detector

Interface
REQ-001 Parameter DINO_X, default 100, track x of dino left edge (integer part).
REQ-002 Parameter DINO_W, default 40, dino width in pixels.
REQ-003 Parameter CACTUS_W, default 24, cactus width in pixels.
REQ-004 Parameter CACTUS_H, default 48, cactus height above ground.
REQ-005 Parameter HIT_CONFIRM, default 2, consecutive overlapping scans required to declare a hit (range 1..7).
REQ-006 Port clk, input, 1, system clock.
REQ-007 Port rst, input, 1, reset: asynchronous, active-low.
REQ-008 Port cactus0..cactus3, input, 12 each, cactus integer positions, two's complement; bit 11 set = off-screen/inactive.
REQ-009 Port cactus_sync, input, 1, one-cycle strobe: positions just updated.
REQ-010 Port dino_alt, input, 10, dino height above ground, 0 = on ground.
REQ-011 Port restart, input, 1, synchronous clear of game state.
REQ-012 Port game_over, output, 1, latched collision flag.
REQ-013 Port hit_index, output, 2, lowest slot index that overlapped in the last scan.
REQ-014 Port score, output, 16, cactuses passed, saturating.
REQ-015 Port scan_done, output, 1, one-cycle pulse when a scan's results are registered.

Function
REQ-016 FSM states SHALL be IDLE, SCAN, EVAL, OVER.
REQ-017 In IDLE, cactus_sync high at edge E0 SHALL snapshot cactus0..3 and dino_alt and enter SCAN.
REQ-018 SCAN SHALL process slot k at edge E(k+1), k=0..3, then enter EVAL; EVAL registers results at E5 and returns to IDLE (or to OVER on hit).
REQ-019 Slot overlap SHALL be: bit 11 clear AND c <= DINO_X+DINO_W-1 AND c+CACTUS_W-1 >= DINO_X AND dino_alt < CACTUS_H; comparisons on 13-bit unsigned zero-extended values.
REQ-020 Slot pass SHALL be: prev[k] and c both with bit 11 clear AND prev[k] <= DINO_X+DINO_W-1 AND c > DINO_X+DINO_W-1.
REQ-021 prev[k] SHALL be updated to the snapshot value of slot k on every completed scan.
REQ-022 hit_cnt (3-bit) SHALL increment on a scan with any overlap and clear to 0 on a scan with none.
REQ-023 When hit_cnt reaches HIT_CONFIRM at E5, game_over SHALL go 1 and FSM SHALL enter OVER.
REQ-024 hit_index SHALL update at E5 only when the scan overlapped; else it holds.
REQ-025 On a non-hit scan, score SHALL add the number of passing slots (0..4), saturating at 0xFFFF; a hit scan SHALL not change score.
REQ-026 scan_done SHALL be high only for the cycle following E5, on every completed scan, including the hit scan.
REQ-027 cactus_sync during SCAN, EVAL or OVER SHALL be ignored (no queuing).
REQ-028 restart SHALL have priority over all other events: game_over=0, score=0, hit_cnt=0, prev[*]=12'hFFF, scan_done=0, hit_index=0, state IDLE, next edge; an in-flight scan is discarded.
REQ-029 In OVER, outputs SHALL hold until restart or rst.

Reset
REQ-030 rst low SHALL immediately force state IDLE, game_over=0, score=0, hit_index=0, scan_done=0, hit_cnt=0, prev[*]=12'hFFF, snapshot registers 0, including mid-SCAN.
REQ-031 The first cactus_sync after rst release SHALL start a scan normally.

Verification
REQ-032 Reset: rst low for 3 cycles -> all outputs 0, next sync produces scan_done exactly 5 edges later.
REQ-033 Hit confirm: cactus0=110, cactus1..3=12'hC00, dino_alt=0, two syncs 20 cycles apart -> first scan game_over=0, hit_index=0; second scan game_over=1 at E5, score=0.
REQ-034 Jump clearance: same positions, dino_alt=60 -> no hit over 5 scans, hit_cnt stays 0, game_over=0.
REQ-035 Scoring: cactus2 = 130 then 145 on successive syncs, other slots 12'hC00 -> score 0 then 1; wrap 145 -> 12'hFCE -> score unchanged.
REQ-036 Ignored sync and restart: sync asserted at E2 of a scan -> single scan_done; in OVER, restart pulse -> game_over=0, score=0, next sync scans.
REQ-037 Async reset mid-SCAN at E3 -> immediate IDLE, no scan_done, score preserved at 0.
